// File: rtl/wb_regfile_scoreboard.sv
// wb_regfile_scoreboard: MEM/WB writeback consumer with a 4 x DATA_W
// register file, two bypassed decode read ports and a per-register
// pending-write scoreboard that raises the decode stall.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   wb_write/quarter/data    writeback commit from the MEM/WB latch
//   rd_a_*, rd_b_*           decode read ports (addr, use, data)
//   issue_valid/writes/dest  instruction presented for issue
//   stall                    combinational hold for decode and upstream
//   sb_error                 sticky scoreboard underflow/overflow flag
//   stall_count              saturating count of stalled cycles
module wb_regfile_scoreboard #(
  parameter int DATA_W   = 16,
  parameter int MAX_PEND = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_write,
  input  logic [1:0]        wb_quarter,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [1:0]        rd_a_addr,
  input  logic              rd_a_use,
  output logic [DATA_W-1:0] rd_a_data,
  input  logic [1:0]        rd_b_addr,
  input  logic              rd_b_use,
  output logic [DATA_W-1:0] rd_b_data,
  input  logic              issue_valid,
  input  logic              issue_writes,
  input  logic [1:0]        issue_dest,
  output logic              stall,
  output logic              sb_error,
  output logic [15:0]       stall_count
);

  localparam logic [1:0] PEND_MAX = 2'(MAX_PEND);

  logic [DATA_W-1:0] regs    [4];
  logic [1:0]        cnt     [4];
  logic [1:0]        cnt_nxt [4];

  logic [3:0] wb_hit;
  logic [3:0] inc;
  logic [3:0] dec;
  logic       raw_a;
  logic       raw_b;
  logic       full;
  logic       accept;
  logic       err_set;

  always_comb begin
    for (int r = 0; r < 4; r++) begin
      wb_hit[r] = wb_write && (wb_quarter == 2'(r));
    end
  end

  always_comb begin
    rd_a_data = regs[rd_a_addr];
    rd_b_data = regs[rd_b_addr];
    if (wb_hit[rd_a_addr]) rd_a_data = wb_data;
    if (wb_hit[rd_b_addr]) rd_b_data = wb_data;
  end

  // A single outstanding write that lands this cycle is covered
  // by the bypass, so it is not a hazard.
  always_comb begin
    raw_a = rd_a_use && (cnt[rd_a_addr] != 2'd0)
         && !((cnt[rd_a_addr] == 2'd1) && wb_hit[rd_a_addr]);
    raw_b = rd_b_use && (cnt[rd_b_addr] != 2'd0)
         && !((cnt[rd_b_addr] == 2'd1) && wb_hit[rd_b_addr]);
    full  = issue_valid && issue_writes
         && (cnt[issue_dest] == PEND_MAX)
         && !wb_hit[issue_dest];
    stall  = !rst && issue_valid && (raw_a || raw_b || full);
    accept = issue_valid && !stall;
  end

  always_comb begin
    for (int r = 0; r < 4; r++) begin
      inc[r] = accept && issue_writes && (issue_dest == 2'(r));
      dec[r] = wb_hit[r];
    end
  end

  // Overflow cannot happen while FULL gates issue; it is still
  // saturated and flagged so a broken upstream is visible.
  always_comb begin
    err_set = 1'b0;
    for (int r = 0; r < 4; r++) begin
      cnt_nxt[r] = cnt[r];
      unique case ({inc[r], dec[r]})
        2'b10: begin
          if (cnt[r] == PEND_MAX) err_set = 1'b1;
          else cnt_nxt[r] = cnt[r] + 2'd1;
        end
        2'b01: begin
          if (cnt[r] == 2'd0) err_set = 1'b1;
          else cnt_nxt[r] = cnt[r] - 2'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < 4; r++) begin
        regs[r] <= '0;
        cnt[r]  <= 2'd0;
      end
      sb_error    <= 1'b0;
      stall_count <= 16'd0;
    end else begin
      if (wb_write) regs[wb_quarter] <= wb_data;
      for (int r = 0; r < 4; r++) begin
        cnt[r] <= cnt_nxt[r];
      end
      if (err_set) sb_error <= 1'b1;
      if (stall && (stall_count != 16'hFFFF))
        stall_count <= stall_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_wb_regfile_scoreboard.sv
// Bench for wb_regfile_scoreboard: directed vector table followed by
// random traffic checked against a pending-count reference model.
module tb_wb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_write;
  logic [1:0]  wb_quarter;
  logic [15:0] wb_data;
  logic [1:0]  rd_a_addr;
  logic        rd_a_use;
  logic [15:0] rd_a_data;
  logic [1:0]  rd_b_addr;
  logic        rd_b_use;
  logic [15:0] rd_b_data;
  logic        issue_valid;
  logic        issue_writes;
  logic [1:0]  issue_dest;
  logic        stall;
  logic        sb_error;
  logic [15:0] stall_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  wb_regfile_scoreboard #(.DATA_W(16), .MAX_PEND(3)) dut (
    .clk(clk), .rst(rst),
    .wb_write(wb_write), .wb_quarter(wb_quarter), .wb_data(wb_data),
    .rd_a_addr(rd_a_addr), .rd_a_use(rd_a_use), .rd_a_data(rd_a_data),
    .rd_b_addr(rd_b_addr), .rd_b_use(rd_b_use), .rd_b_data(rd_b_data),
    .issue_valid(issue_valid), .issue_writes(issue_writes),
    .issue_dest(issue_dest),
    .stall(stall), .sb_error(sb_error), .stall_count(stall_count)
  );

  typedef struct {
    logic        rst, wbw;
    logic [1:0]  wbq;
    logic [15:0] wbd;
    logic [1:0]  aa;
    logic        au;
    logic [1:0]  ba;
    logic        bu;
    logic        iv, iw;
    logic [1:0]  id;
    logic [15:0] ea, eb;
    logic        es, ee;
    logic [15:0] ec;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    logic r, logic w, logic [1:0] q, logic [15:0] d,
    logic [1:0] aa, logic au, logic [1:0] ba, logic bu,
    logic iv, logic iw, logic [1:0] id,
    logic [15:0] ea, logic [15:0] eb,
    logic es, logic ee, logic [15:0] ec);
    vec_t v;
    v.rst = r; v.wbw = w; v.wbq = q; v.wbd = d;
    v.aa = aa; v.au = au; v.ba = ba; v.bu = bu;
    v.iv = iv; v.iw = iw; v.id = id;
    v.ea = ea; v.eb = eb; v.es = es; v.ee = ee; v.ec = ec;
    return v;
  endfunction

  task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(vec_t v);
    rst = v.rst; wb_write = v.wbw; wb_quarter = v.wbq; wb_data = v.wbd;
    rd_a_addr = v.aa; rd_a_use = v.au;
    rd_b_addr = v.ba; rd_b_use = v.bu;
    issue_valid = v.iv; issue_writes = v.iw; issue_dest = v.id;
  endtask

  task automatic finish_cycle();
    @(posedge clk);
    #1;
  endtask

  // Reference model: pending write counts as plain integers.
  int          pend [4];
  logic [15:0] mregs [4];
  bit          merr;
  int          mcnt;

  function automatic bit hit(vec_t v, logic [1:0] r);
    return v.wbw && v.wbq == r;
  endfunction

  function automatic bit blocked(vec_t v, logic u, logic [1:0] a);
    if (!u || pend[a] == 0) return 0;
    return !(pend[a] == 1 && hit(v, a));
  endfunction

  function automatic vec_t predict(vec_t v);
    vec_t e = v;
    bit full;
    e.ea = hit(v, v.aa) ? v.wbd : mregs[v.aa];
    e.eb = hit(v, v.ba) ? v.wbd : mregs[v.ba];
    full = v.iv && v.iw && pend[v.id] >= 3 && !hit(v, v.id);
    e.es = !v.rst && v.iv &&
           (blocked(v, v.au, v.aa) || blocked(v, v.bu, v.ba) || full);
    e.ee = merr;
    e.ec = 16'(mcnt);
    return e;
  endfunction

  task automatic model_edge(vec_t v, bit stalled);
    if (v.rst) begin
      foreach (pend[r]) begin pend[r] = 0; mregs[r] = 16'h0; end
      merr = 0; mcnt = 0;
    end else begin
      for (int r = 0; r < 4; r++) begin
        int n = pend[r];
        if (v.iv && !stalled && v.iw && v.id == 2'(r)) n++;
        if (hit(v, 2'(r))) n--;
        if (n < 0) begin n = 0; merr = 1; end
        if (n > 3) begin n = 3; merr = 1; end
        pend[r] = n;
      end
      if (v.wbw) mregs[v.wbq] = v.wbd;
      if (stalled && mcnt < 65535) mcnt++;
    end
  endtask

  initial begin
    vec_t v, e;
    vec_t idle;
    idle = mk(0,0,0,0, 0,0,0,0, 0,0,0, 0,0,0,0,0);

    // rst, wbw,q,data, aa,au,ba,bu, iv,iw,id, ea,eb, es,ee,cnt
    tbl.push_back(mk(0,0,0,0,      0,0,1,0, 0,0,0, 0,0, 0,0,0));
    tbl.push_back(mk(0,0,0,0,      2,0,3,0, 0,0,0, 0,0, 0,0,0));
    tbl.push_back(mk(0,0,0,0,      0,0,0,0, 1,1,2, 0,0, 0,0,0));
    tbl.push_back(mk(0,1,2,'hBEEF, 2,0,2,0, 0,0,0, 'hBEEF,'hBEEF, 0,0,0));
    tbl.push_back(mk(0,0,0,0,      2,0,1,0, 0,0,0, 'hBEEF,0, 0,0,0));
    tbl.push_back(mk(0,0,0,0,      0,0,0,0, 1,1,1, 0,0, 0,0,0));
    tbl.push_back(mk(0,0,0,0,      1,1,2,0, 1,0,0, 0,'hBEEF, 1,0,0));
    tbl.push_back(mk(0,0,0,0,      1,1,2,0, 1,0,0, 0,'hBEEF, 1,0,1));
    tbl.push_back(mk(0,1,1,'h0042, 1,1,2,0, 1,0,0, 'h0042,'hBEEF, 0,0,2));
    tbl.push_back(mk(0,0,0,0,      1,1,2,0, 1,0,0, 'h0042,'hBEEF, 0,0,2));
    tbl.push_back(mk(0,0,0,0,      3,0,0,0, 1,1,3, 0,0, 0,0,2));
    tbl.push_back(mk(0,0,0,0,      3,0,0,0, 1,1,3, 0,0, 0,0,2));
    tbl.push_back(mk(0,0,0,0,      3,0,0,0, 1,1,3, 0,0, 0,0,2));
    tbl.push_back(mk(0,0,0,0,      3,0,0,0, 1,1,3, 0,0, 1,0,2));
    tbl.push_back(mk(0,1,3,'h1234, 3,0,0,0, 1,1,3, 'h1234,0, 0,0,3));
    tbl.push_back(mk(0,0,0,0,      3,0,0,0, 1,1,3, 'h1234,0, 1,0,3));
    tbl.push_back(mk(0,0,0,0,      0,0,0,0, 1,1,0, 0,0, 0,0,4));
    tbl.push_back(mk(0,1,0,'h0A0A, 0,0,0,0, 1,1,0, 'h0A0A,'h0A0A, 0,0,4));
    tbl.push_back(mk(0,0,0,0,      0,1,0,0, 1,0,0, 'h0A0A,'h0A0A, 1,0,4));
    tbl.push_back(mk(0,1,0,'h0B0B, 0,0,0,0, 0,0,0, 'h0B0B,'h0B0B, 0,0,5));
    tbl.push_back(mk(0,0,0,0,      0,1,0,0, 1,0,0, 'h0B0B,'h0B0B, 0,0,5));
    tbl.push_back(mk(0,1,0,'h0C0C, 0,0,0,0, 0,0,0, 'h0C0C,'h0C0C, 0,0,5));
    tbl.push_back(mk(0,0,0,0,      0,0,0,0, 0,0,0, 'h0C0C,'h0C0C, 0,1,5));
    tbl.push_back(mk(0,1,3,'h5555, 3,0,0,0, 0,0,0, 'h5555,'h0C0C, 0,1,5));
    tbl.push_back(mk(0,0,0,0,      2,0,3,0, 1,1,2, 'hBEEF,'h5555, 0,1,5));
    tbl.push_back(mk(0,0,0,0,      2,0,3,0, 1,1,2, 'hBEEF,'h5555, 0,1,5));
    tbl.push_back(mk(1,1,2,'hFFFF, 2,1,3,0, 1,1,2, 'hFFFF,'h5555, 0,1,5));
    tbl.push_back(mk(0,0,0,0,      2,0,3,0, 0,0,0, 0,0, 0,0,0));
    tbl.push_back(mk(0,0,0,0,      2,1,3,1, 1,0,0, 0,0, 0,0,0));
    tbl.push_back(mk(0,1,2,'h7777, 2,0,3,0, 0,0,0, 'h7777,0, 0,0,0));
    tbl.push_back(mk(0,0,0,0,      2,0,3,0, 0,0,0, 'h7777,0, 0,1,0));

    v = idle;
    v.rst = 1;
    drive(v);
    finish_cycle();
    finish_cycle();

    foreach (tbl[i]) begin
      drive(tbl[i]);
      @(negedge clk);
      chk($sformatf("vec%0d rd_a", i), rd_a_data, tbl[i].ea);
      chk($sformatf("vec%0d rd_b", i), rd_b_data, tbl[i].eb);
      chk($sformatf("vec%0d stall", i), 16'(stall), 16'(tbl[i].es));
      chk($sformatf("vec%0d sb_error", i), 16'(sb_error), 16'(tbl[i].ee));
      chk($sformatf("vec%0d stall_count", i), stall_count, tbl[i].ec);
      finish_cycle();
    end

    v = idle;
    v.rst = 1;
    drive(v);
    model_edge(v, 0);
    finish_cycle();

    for (int c = 0; c < 600; c++) begin
      int busy[$];
      v = idle;
      v.rst = ($urandom_range(0, 59) == 0);
      v.aa = 2'($urandom); v.au = 1'($urandom);
      v.ba = 2'($urandom); v.bu = 1'($urandom);
      v.iv = ($urandom_range(0, 3) != 0);
      v.iw = 1'($urandom);
      v.id = 2'($urandom);
      v.wbd = 16'($urandom);
      foreach (pend[r]) if (pend[r] > 0) busy.push_back(r);
      if (busy.size() > 0 && $urandom_range(0, 1) == 1) begin
        v.wbw = 1;
        v.wbq = 2'(busy[$urandom_range(0, busy.size() - 1)]);
      end else if ($urandom_range(0, 19) == 0) begin
        v.wbw = 1;
        v.wbq = 2'($urandom);
      end
      if (!v.wbw) v.wbd = 16'h0;
      e = predict(v);
      drive(v);
      @(negedge clk);
      chk($sformatf("rnd%0d rd_a", c), rd_a_data, e.ea);
      chk($sformatf("rnd%0d rd_b", c), rd_b_data, e.eb);
      chk($sformatf("rnd%0d stall", c), 16'(stall), 16'(e.es));
      chk($sformatf("rnd%0d sb_error", c), 16'(sb_error), 16'(e.ee));
      chk($sformatf("rnd%0d stall_count", c), stall_count, e.ec);
      model_edge(v, e.es);
      finish_cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
